// File: rtl/pulsar_uart_pkg.sv
// pulsar_uart_pkg: framing constants, state types and checksum shared by the pulsar UART tx/rx.
package pulsar_uart_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int FRAME_LEN = 4;
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [1:0] {F_SYNC, F_HI, F_LO, F_CHK} frame_state_t;
  function automatic logic [7:0] checksum(input logic [7:0] sync, input logic [7:0] hi, input logic [7:0] lo);
    return sync ^ hi ^ lo;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with input synchroniser; byte strobe and stop error are combinational on the stop sample.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = pulsar_uart_pkg::CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       uart_rx_pin,
  output logic [7:0] data,
  output logic       stb,
  output logic       stop_err,
  output logic       idle
);
  import pulsar_uart_pkg::*;
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic rx_m, rx_s, bad, last;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  bit_state_t st;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  assign stb = st == B_STOP && !bad && last && rx_s;
  assign stop_err = st == B_STOP && !bad && last && !rx_s;
  assign idle = st == B_IDLE;
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      st <= B_IDLE;
      cnt <= '0;
      idx <= '0;
      bad <= 1'b0;
      data <= '0;
    end else begin
      rx_m <= uart_rx_pin;
      rx_s <= rx_m;
      case (st)
        B_IDLE: begin
          cnt <= '0;
          idx <= '0;
          bad <= 1'b0;
          if (!rx_s) st <= B_START;
        end
        B_START:
          if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
            cnt <= '0;
            st <= rx_s ? B_IDLE : B_DATA;
          end else cnt <= cnt + 1'b1;
        B_DATA:
          if (last) begin
            cnt <= '0;
            data <= {rx_s, data[7:1]};
            idx <= idx + 1'b1;
            if (idx == 3'd7) st <= B_STOP;
          end else cnt <= cnt + 1'b1;
        B_STOP:
          // after a bad stop bit, hold here until the line returns high
          if (bad) begin
            if (rx_s) st <= B_IDLE;
          end else if (last) begin
            cnt <= '0;
            if (rx_s) st <= B_IDLE;
            else bad <= 1'b1;
          end else cnt <= cnt + 1'b1;
        default: st <= B_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/period_frame_rx.sv
// period_frame_rx: decodes A5/hi/lo/xor frames from the UART line into a verified 16-bit period.
module period_frame_rx #(
  parameter int         CLKS_PER_BIT     = pulsar_uart_pkg::CLKS_PER_BIT_DEFAULT,
  parameter logic [7:0] SYNC_BYTE        = pulsar_uart_pkg::SYNC_BYTE,
  parameter int         GAP_TIMEOUT_BITS = 20
) (
  input  logic        clk_50mhz,
  input  logic        rst_n,
  input  logic        uart_rx_pin,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic [15:0] period_us,
  output logic        period_valid,
  output logic        frame_err
);
  import pulsar_uart_pkg::*;
  localparam int GAP_MAX = GAP_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GW = $clog2(GAP_MAX);
  logic [7:0] rx_data, hi, lo;
  logic stb, stop_err, bit_idle;
  logic [GW-1:0] gap;
  frame_state_t fst;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_50mhz(clk_50mhz),
    .rst_n(rst_n),
    .uart_rx_pin(uart_rx_pin),
    .data(rx_data),
    .stb(stb),
    .stop_err(stop_err),
    .idle(bit_idle)
  );
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte <= '0;
      rx_byte_valid <= 1'b0;
      period_us <= '0;
      period_valid <= 1'b0;
      frame_err <= 1'b0;
      hi <= '0;
      lo <= '0;
      gap <= '0;
      fst <= F_SYNC;
    end else begin
      rx_byte_valid <= stb;
      period_valid <= 1'b0;
      frame_err <= 1'b0;
      if (stb) begin
        rx_byte <= rx_data;
        gap <= '0;
        case (fst)
          F_SYNC: if (rx_data == SYNC_BYTE) fst <= F_HI;
          F_HI: begin
            hi <= rx_data;
            fst <= F_LO;
          end
          F_LO: begin
            lo <= rx_data;
            fst <= F_CHK;
          end
          default: begin
            if (rx_data == checksum(SYNC_BYTE, hi, lo)) begin
              period_us <= {hi, lo};
              period_valid <= 1'b1;
            end else frame_err <= 1'b1;
            fst <= F_SYNC;
          end
        endcase
      end else if (stop_err) begin
        frame_err <= 1'b1;
        gap <= '0;
        fst <= F_SYNC;
      end else if (fst == F_SYNC) begin
        gap <= '0;
      end else if (bit_idle) begin
        // gap only advances between bytes; it holds while a byte is on the wire
        if (gap == GW'(GAP_MAX - 1)) begin
          frame_err <= 1'b1;
          gap <= '0;
          fst <= F_SYNC;
        end else gap <= gap + 1'b1;
      end
    end
  end
endmodule
